ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device transmitter for the PS/2 port: accepts one command byte from system logic (e.g. 8'hED set-LEDs, 8'hF4 enable), runs the PS/2 request-to-send sequence, and shifts the byte, odd parity and stop bit out on the device-generated clock. It then checks the device's line ACK. It sits beside the PS/2 keyboard receiver on the same open-collector lines. The device's 8'hFA response byte is picked up by the receiver, not by this block.

## Interface
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- INHIBIT_US, 100: duration the host holds PS/2 clock low before requesting to send.
- TIMEOUT_US, 15000: maximum time from request-to-send to line ACK.
- clock  in  1  system clock. All logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request. The byte is accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clock_in  in  1  raw PS/2 clock line (pad input).
- ps2_data_in  in  1  raw PS/2 data line (pad input).
- ps2_clock_oe  out  1  1 = pull PS/2 clock low, 0 = release (pad is open-drain).
- ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release.
- busy  out  1  high in every state except IDLE. The receiver uses it to ignore traffic.
- tx_done  out  1  one-cycle pulse when the device ACKed and the lines have returned idle.
- tx_error  out  1  one-cycle pulse on timeout or missing ACK.

## Operation
- Input conditioning: ps2_clock_in and ps2_data_in pass through 2-flop synchronizers. fall = sync_clk_d & ~sync_clk.
- Constants: INHIBIT_CYC = CLK_FREQ_HZ/1_000_000*INHIBIT_US. TIMEOUT_CYC is computed the same way. Counter width is $clog2(TIMEOUT_CYC+1).
- Capture on accept: shreg = {1'b1 stop, ~^tx_data parity, tx_data}. This is 10 bits, sent LSB first.
- States:
  - IDLE: both oe = 0. On accept, latch shreg, load timer = INHIBIT_CYC, go to INHIBIT.
  - INHIBIT: ps2_clock_oe = 1. When the timer reaches 0, set ps2_data_oe = 1 (start bit), load timer = TIMEOUT_CYC and bitcnt = 0, and go to REQ.
  - REQ: release ps2_clock_oe and hold data low. On fall, drive bit shreg[0] (ps2_data_oe = ~shreg[0]), shift right, bitcnt = 1, go to SEND.
  - SEND: on each fall with bitcnt < 10, drive the next bit and increment bitcnt. On the 10th fall the stop bit is driven, which releases data (oe = 0). Go to ACK.
  - ACK: on the next fall, sample sync_data. 0 → WAIT_IDLE. 1 → ERROR.
  - WAIT_IDLE: when sync_clk && sync_data are both high, pulse tx_done and go to IDLE.
  - ERROR: both oe = 0, pulse tx_error, go to IDLE.
- Timeout: the timer decrements every cycle in REQ, SEND, ACK and WAIT_IDLE. Reaching 0 in any of these states goes to ERROR.
- Parity is odd: the 8 data bits plus the parity bit contain an odd number of 1s.
- tx_valid while busy is ignored; no queueing. tx_data is sampled only at accept.

## Timing
- Reset values: every output is 0 except tx_ready = 1. The state is IDLE. Assertion releases both lines immediately (asynchronously), including mid-transfer.
- Line changes caused by the device appear at the FSM 2 cycles later (synchronizer) and act on the 3rd cycle. ps2_data_oe updates on the cycle after a fall is detected.
- Accept to ps2_clock_oe = 1: 1 cycle.
- Clock low is held for exactly INHIBIT_CYC cycles. data_oe rises in the same cycle clock_oe falls.
- tx_done is 1 cycle wide and asserts the first cycle both synchronized lines read high after the ACK.
- ACK sampled = 1, or timer reaching 0: tx_error is asserted the following cycle. tx_ready returns high the cycle after that.
- tx_done and tx_error never assert together. After either, the earliest new accept is 1 cycle later.

## Structure
- Shared include ps2_defs.vh holds:
  - state encodings (3-bit localparams);
  - command constants: PS2_CMD_SET_LED 8'hED, PS2_CMD_ECHO 8'hEE, PS2_CMD_RESET 8'hFF, PS2_RSP_ACK 8'hFA, PS2_BREAK 8'hF0.
- One sub-module, ps2_sync_edge: 2-flop synchronizer plus falling-edge detect. It is instantiated once per line and is reusable by the receiver.
- Top-level pad wiring: PS2_CLK = ps2_clock_oe ? 1'b0 : 1'bz. PS2_DAT is wired the same way from ps2_data_oe.

## Test plan
- Bench uses CLK_FREQ_HZ = 1_000_000, INHIBIT_US = 100, TIMEOUT_US = 2000, and a device model clocking at 10 kHz.
- Send 8'hED; the model ACKs. The model must capture start 0, bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1. Then exactly one tx_done, no tx_error, tx_ready back high.
- Send 8'h00; the model ACKs. Parity bit must be 1. Check ps2_clock_oe is high for exactly 100 cycles with ps2_data_oe = 1 at its release.
- Send 8'hF4; the model leaves data high at ACK. Expect a tx_error pulse, both oe = 0, no tx_done.
- Model never clocks after request. Expect tx_error exactly 2000 cycles after REQ entry; lines released.
- Assert resetn low after the 5th data fall. Both oe must drop to 0 in the same cycle, tx_ready = 1 after reset. A subsequent 8'hEE send completes with tx_done.
- Pulse tx_valid with 8'h55 during an 8'hED transfer. Only 8'hED appears on the line, and exactly one tx_done is produced.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx_pkg
// Brief   : Shared PS/2 host definitions: FSM state codes, command bytes and
//           the frame parity helper.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_host_tx_pkg;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_inhibit   = 3'd1;
    localparam logic [2:0] c_st_req       = 3'd2;
    localparam logic [2:0] c_st_send      = 3'd3;
    localparam logic [2:0] c_st_ack       = 3'd4;
    localparam logic [2:0] c_st_wait_idle = 3'd5;
    localparam logic [2:0] c_st_error     = 3'd6;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_BREAK       = 8'hF0;

    // Odd parity: data bits plus this bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ps2_sync_edge
// Brief   : Two-flop synchronizer for one PS/2 line plus falling-edge detect.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_sync_edge (
    input  logic clock,
    input  logic resetn,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Reset to the idle (pulled-up) level so no edge is seen leaving reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= i_line;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_sync_d & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device command transmitter (request-to-send, 10-bit
//           shift on device clock, line ACK check). Board level wires each
//           pad as  PS2_x = x_oe ? 1'b0 : 1'bz.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_inhibit_cyc = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int c_timeout_cyc = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int c_tmr_w       = $clog2(c_timeout_cyc + 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_tmr_w-1:0] r_timer;
    logic [9:0]         r_shreg;
    logic [3:0]         r_bitcnt;
    logic               r_data_drv;

    logic w_sync_clk;
    logic w_clk_fall;
    logic w_sync_dat;
    logic w_accept;
    logic w_tmr_last;
    logic w_line_idle;

    ps2_sync_edge u_sync_clk (
        .clock  (clock),
        .resetn (resetn),
        .i_line (ps2_clock_in),
        .o_sync (w_sync_clk),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clock  (clock),
        .resetn (resetn),
        .i_line (ps2_data_in),
        .o_sync (w_sync_dat),
        .o_fall ()
    );

    assign w_accept    = tx_valid && (r_state == c_st_idle);
    // The timer is left on the transition that takes it to zero, so a load of
    // N gives exactly N cycles in the timed state(s).
    assign w_tmr_last  = (r_timer <= c_tmr_w'(1));
    assign w_line_idle = w_sync_clk && w_sync_dat;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nxt = c_st_inhibit;
            end
            c_st_inhibit: begin
                if (w_tmr_last) w_state_nxt = c_st_req;
            end
            c_st_req: begin
                if (w_tmr_last)      w_state_nxt = c_st_error;
                else if (w_clk_fall) w_state_nxt = c_st_send;
            end
            c_st_send: begin
                if (w_tmr_last)                             w_state_nxt = c_st_error;
                else if (w_clk_fall && (r_bitcnt == 4'd9))  w_state_nxt = c_st_ack;
            end
            c_st_ack: begin
                if (w_tmr_last)      w_state_nxt = c_st_error;
                else if (w_clk_fall) w_state_nxt = w_sync_dat ? c_st_error : c_st_wait_idle;
            end
            c_st_wait_idle: begin
                if (w_line_idle)     w_state_nxt = c_st_idle;
                else if (w_tmr_last) w_state_nxt = c_st_error;
            end
            c_st_error: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_timer    <= '0;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_data_drv <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_data_drv <= 1'b0;
                    if (w_accept) begin
                        r_shreg <= {1'b1, odd_parity(tx_data), tx_data};
                        r_timer <= c_tmr_w'(c_inhibit_cyc);
                    end
                end
                c_st_inhibit: begin
                    if (w_tmr_last) begin
                        r_timer  <= c_tmr_w'(c_timeout_cyc);
                        r_bitcnt <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_st_req, c_st_send, c_st_ack, c_st_wait_idle: begin
                    if (r_timer != '0) r_timer <= r_timer - 1'b1;
                    if (w_clk_fall && (r_state == c_st_req || r_state == c_st_send)) begin
                        r_data_drv <= ~r_shreg[0];
                        r_shreg    <= {1'b0, r_shreg[9:1]};
                        r_bitcnt   <= r_bitcnt + 4'd1;
                    end
                end
                default: r_data_drv <= 1'b0;
            endcase
        end
    end

    always_comb begin
        ps2_clock_oe = (r_state == c_st_inhibit);
        ps2_data_oe  = (r_state == c_st_req) || ((r_state == c_st_send) && r_data_drv);
        tx_ready     = (r_state == c_st_idle);
        busy         = (r_state != c_st_idle);
        tx_done      = (r_state == c_st_wait_idle) && w_line_idle;
        tx_error     = (r_state == c_st_error);
    end

endmodule
`default_nettype wire
